branch_trap_resolver: RTL and testbench

- Consumes the condition flags produced by the ALU comparator and turns them into control-flow actions.
- Accepts one decoded branch/trap op at a time from decode. Drives the comparator op code and operands, then registers the returned flags.
- Resolves taken/not-taken, issues a PC redirect to fetch, a link-register write, or a trap request to the exception unit.

---
 rtl/branch_trap_resolver_pkg.sv | 48 ++++
 rtl/branch_trap_resolver_op_map.sv | 39 +++
 rtl/branch_trap_resolver.sv | 166 ++++++++++++++++
 tb/tb_branch_trap_resolver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_trap_resolver_pkg.sv
// Shared types and constants for the branch/trap resolver.
// Optional branch-likely support is selected with the BRANCH_LIKELY_EN macro.
package branch_pkg;

    typedef enum logic [3:0] {
        BEQ    = 4'd0,
        BNE    = 4'd1,
        BGEZ   = 4'd2,
        BGEZAL = 4'd3,
        BLTZ   = 4'd4,
        BLTZAL = 4'd5,
        BGTZ   = 4'd6,
        BLEZ   = 4'd7,
        TEQ    = 4'd8,
        TNE    = 4'd9,
        TGE    = 4'd10,
        TGEU   = 4'd11,
        TLT    = 4'd12,
        TLTU   = 4'd13
    } br_op_t;

    localparam logic [3:0] CMP_GEZ = 4'd7;
    localparam logic [3:0] CMP_EQ  = 4'd8;
    localparam logic [3:0] CMP_LTZ = 4'd9;
    localparam logic [3:0] CMP_GTZ = 4'd10;
    localparam logic [3:0] CMP_LEZ = 4'd11;
    localparam logic [3:0] CMP_NE  = 4'd12;
    localparam logic [3:0] CMP_GE  = 4'd14;
    localparam logic [3:0] CMP_LT  = 4'd15;

    localparam logic [1:0] FLG_COND = 2'd0;
    localparam logic [1:0] FLG_S    = 2'd2;
    localparam logic [1:0] FLG_U    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMP      = 3'd1,
        S_RESOLVE  = 3'd2,
        S_REDIRECT = 3'd3,
        S_TRAP     = 3'd4
    } state_t;

    // Codes 14 and 15 have no op assigned.
    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'd13;
    endfunction

endpackage

// File: rtl/branch_trap_resolver_op_map.sv
// Decodes a branch/trap op into comparator op, flag bit to test, and op class.
module br_op_map
    import branch_pkg::*;
(
    input  logic [3:0] op,
    output logic [3:0] cmp_op,
    output logic [1:0] flag_sel,
    output logic       is_trap,
    output logic       is_link,
    output logic       legal
);

    // Pure lookup; unassigned codes decode as illegal with no comparator op.
    always_comb begin
        cmp_op   = 4'd0;
        flag_sel = FLG_COND;
        is_trap  = 1'b0;
        is_link  = 1'b0;
        legal    = 1'b1;
        case (op)
            BEQ:    cmp_op = CMP_EQ;
            BNE:    cmp_op = CMP_NE;
            BGEZ:   cmp_op = CMP_GEZ;
            BGEZAL: begin cmp_op = CMP_GEZ; is_link = 1'b1; end
            BLTZ:   cmp_op = CMP_LTZ;
            BLTZAL: begin cmp_op = CMP_LTZ; is_link = 1'b1; end
            BGTZ:   cmp_op = CMP_GTZ;
            BLEZ:   cmp_op = CMP_LEZ;
            TEQ:    begin cmp_op = CMP_EQ; is_trap = 1'b1; end
            TNE:    begin cmp_op = CMP_NE; is_trap = 1'b1; end
            TGE:    begin cmp_op = CMP_GE; flag_sel = FLG_S; is_trap = 1'b1; end
            TGEU:   begin cmp_op = CMP_GE; flag_sel = FLG_U; is_trap = 1'b1; end
            TLT:    begin cmp_op = CMP_LT; flag_sel = FLG_S; is_trap = 1'b1; end
            TLTU:   begin cmp_op = CMP_LT; flag_sel = FLG_U; is_trap = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_trap_resolver.sv
// Branch/trap resolver: sequences one op through the ALU comparator, then
// issues a fetch redirect, link write or trap request.
// Build option: define BRANCH_LIKELY_EN to pulse annul on not-taken likely branches.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable payload until that edge.
module branch_trap_resolver
    import branch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic              req_likely,
    input  logic [31:0]       req_rs,
    input  logic [31:0]       req_rt,
    input  logic [15:0]       req_imm,
    input  logic [ADDR_W-1:0] req_pc,
    output logic [3:0]        cmp_op,
    output logic [31:0]       cmp_a,
    output logic [31:0]       cmp_b,
    input  logic [3:0]        cmp_flags,
    output logic              res_valid,
    output logic              res_taken,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [ADDR_W-1:0] redir_pc,
    output logic              link_we,
    output logic [4:0]        link_addr,
    output logic [31:0]       link_data,
    output logic              trap_req,
    input  logic              trap_ack,
    output logic              annul,
    output logic [2:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [31:0]       rs_q, rt_q;
    logic [15:0]       imm_q;
    logic [ADDR_W-1:0] pc_q;
    logic              likely_q;
    logic [3:0]        flags_q;

    logic [3:0]        map_cmp_op;
    logic [1:0]        map_flag_sel;
    logic              map_is_trap, map_is_link, map_legal;
    logic              cond;
    logic [ADDR_W-1:0] target;

    br_op_map u_map (
        .op       (op_q),
        .cmp_op   (map_cmp_op),
        .flag_sel (map_flag_sel),
        .is_trap  (map_is_trap),
        .is_link  (map_is_link),
        .legal    (map_legal)
    );

    assign cond      = flags_q[map_flag_sel];
    assign target    = pc_q + ADDR_W'(4) + ({{(ADDR_W-16){imm_q[15]}}, imm_q} << 2);
    assign dbg_state = state_q;

`ifndef BRANCH_LIKELY_EN
    logic unused_likely;
    assign unused_likely = likely_q;
`endif

    // State register, request capture on accept, flag capture in CMP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            rs_q     <= 32'd0;
            rt_q     <= 32'd0;
            imm_q    <= 16'd0;
            pc_q     <= '0;
            likely_q <= 1'b0;
            flags_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                op_q     <= req_op;
                rs_q     <= req_rs;
                rt_q     <= req_rt;
                imm_q    <= req_imm;
                pc_q     <= req_pc;
                likely_q <= req_likely;
            end
            if (state_q == S_CMP) begin
                flags_q <= cmp_flags;
            end
        end
    end

    // Next state and outputs; flush forces IDLE and silences every strobe.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        cmp_op      = 4'd0;
        cmp_a       = 32'd0;
        cmp_b       = 32'd0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        link_we     = 1'b0;
        link_addr   = 5'd0;
        link_data   = 32'd0;
        trap_req    = 1'b0;
        annul       = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        // Illegal ops skip the comparator and resolve next cycle.
                        state_d = op_is_legal(req_op) ? S_CMP : S_RESOLVE;
                    end
                end
                S_CMP: begin
                    cmp_op  = map_cmp_op;
                    cmp_a   = rs_q;
                    cmp_b   = rt_q;
                    state_d = S_RESOLVE;
                end
                S_RESOLVE: begin
                    res_valid = 1'b1;
                    state_d   = S_IDLE;
                    if (map_legal) begin
                        res_taken = cond;
                        if (map_is_link) begin
                            link_we   = 1'b1;
                            link_addr = 5'(LINK_REG);
                            link_data = 32'(pc_q + ADDR_W'(8));
                        end
`ifdef BRANCH_LIKELY_EN
                        annul = likely_q && !map_is_trap && !cond;
`endif
                        if (cond) begin
                            state_d = map_is_trap ? S_TRAP : S_REDIRECT;
                        end
                    end
                end
                S_REDIRECT: begin
                    redir_valid = 1'b1;
                    redir_pc    = target;
                    if (redir_ready) state_d = S_IDLE;
                end
                S_TRAP: begin
                    trap_req = 1'b1;
                    if (trap_ack) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_trap_resolver.sv
// Self-checking bench for branch_trap_resolver: directed plan cases plus a
// random sweep, with a scoreboard of expected resolve/redirect/trap events.
module tb_branch_trap_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_likely;
    logic [31:0] req_rs, req_rt;
    logic [15:0] req_imm;
    logic [31:0] req_pc;
    logic [3:0]  cmp_op;
    logic [31:0] cmp_a, cmp_b;
    logic [3:0]  cmp_flags;
    logic        res_valid, res_taken;
    logic        redir_valid, redir_ready;
    logic [31:0] redir_pc;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        trap_req, trap_ack;
    logic        annul;
    logic [2:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // res entry: {annul, res_taken, link_we, link_data}
    logic [34:0] res_q[$];
    logic [31:0] redir_q[$];
    logic [31:0] trap_q[$];
    logic [34:0] mon_e;

    branch_trap_resolver #(.ADDR_W(32), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_likely(req_likely), .req_rs(req_rs), .req_rt(req_rt),
        .req_imm(req_imm), .req_pc(req_pc),
        .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_flags(cmp_flags),
        .res_valid(res_valid), .res_taken(res_taken),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
        .trap_req(trap_req), .trap_ack(trap_ack), .annul(annul),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_cmp(input logic [3:0] op);
        case (op)
            4'd0, 4'd8:   return 4'd8;
            4'd1, 4'd9:   return 4'd12;
            4'd2, 4'd3:   return 4'd7;
            4'd4, 4'd5:   return 4'd9;
            4'd6:         return 4'd10;
            4'd7:         return 4'd11;
            4'd10, 4'd11: return 4'd14;
            4'd12, 4'd13: return 4'd15;
            default:      return 4'd0;
        endcase
    endfunction

    function automatic logic exp_cond(input logic [3:0] op, input logic [3:0] flags);
        if (op == 4'd10 || op == 4'd12) return flags[2];
        if (op == 4'd11 || op == 4'd13) return flags[3];
        return flags[0];
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (res_valid) begin
                if (res_q.size() == 0) check("res_unexpected", 1, 0);
                else begin
                    mon_e = res_q.pop_front();
                    check("res", {annul, res_taken, link_we, link_data}, mon_e);
                end
            end
            if (link_we) check("link_addr", link_addr, 31);
            if (redir_valid) begin
                if (redir_q.size() == 0) check("redir_unexpected", 1, 0);
                else begin
                    check("redir_pc", redir_pc, redir_q[0]);
                    if (redir_ready) void'(redir_q.pop_front());
                end
            end
            if (trap_req && trap_ack) begin
                if (trap_q.size() == 0) check("trap_unexpected", 1, 0);
                else check("trap_pc", req_pc, trap_q.pop_front());
            end
        end
    end

    // Drive one op and follow it back to IDLE.
    task automatic do_op(input logic [3:0] op, input logic likely,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [31:0] pc,
                         input logic [3:0] flags, input int stall,
                         input int ackdly, input int flush_at);
        logic        legal, trap, link, cond, exp_annul, done;
        logic [31:0] target;
        int          n, rv, tr, exp_cyc;
        legal  = (op <= 4'd13);
        trap   = (op >= 4'd8);
        link   = (op == 4'd3 || op == 4'd5);
        cond   = legal && exp_cond(op, flags);
        target = pc + 32'd4 + ({{16{imm[15]}}, imm} << 2);
`ifdef BRANCH_LIKELY_EN
        exp_annul = legal && !trap && likely && !cond;
`else
        exp_annul = 1'b0;
`endif
        res_q.push_back({exp_annul, cond, legal && link, (legal && link) ? pc + 32'd8 : 32'd0});
        if (cond && !trap) redir_q.push_back(target);
        if (cond && trap) trap_q.push_back(pc);
        if (!legal) exp_cyc = 2;
        else if (!cond) exp_cyc = 3;
        else if (flush_at > 0) exp_cyc = flush_at + 1;
        else exp_cyc = 4 + (trap ? ackdly : stall);

        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_likely = likely;
        req_rs = rs; req_rt = rt; req_imm = imm; req_pc = pc;
        redir_ready = (stall == 0); trap_ack = (ackdly == 0);
        flush = 1'b0; cmp_flags = 4'd0;
        @(negedge clk);
        check("req_ready", req_ready, 1);
        n = 0; rv = 0; tr = 0; done = 1'b0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            req_valid = (n == flush_at);
            flush     = (n == flush_at);
            cmp_flags = (n == 1) ? flags : 4'd0;
            if (n >= 3 + stall) redir_ready = 1'b1;
            if (n >= 3 + ackdly) trap_ack = 1'b1;
            @(negedge clk);
            if (n == 1 && legal) begin
                check("cmp_op", cmp_op, exp_cmp(op));
                check("cmp_a", cmp_a, rs);
                check("cmp_b", cmp_b, rt);
            end
            if (n == 2 && !legal) check("cmp_idle", cmp_op, 0);
            if (n == flush_at) begin
                check("flush_ready", req_ready, 0);
                check("flush_redir", redir_valid, 0);
            end
            if (redir_valid) rv++;
            if (trap_req) tr++;
            if (req_ready) done = 1'b1;
        end
        if (!done) check("timeout", 0, 1);
        check("cycles", n, exp_cyc);
        check("redir_cycles", rv, (cond && !trap) ? ((flush_at > 0) ? flush_at - 3 : stall + 1) : 0);
        check("trap_cycles", tr, (cond && trap) ? ackdly + 1 : 0);
        if (flush_at > 0 && cond && !trap && redir_q.size() > 0) void'(redir_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 4'd0;
        req_likely = 1'b0; req_rs = '0; req_rt = '0; req_imm = '0; req_pc = '0;
        cmp_flags = 4'd0; redir_ready = 1'b0; trap_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_state", dbg_state, 0);
        check("rst_outs", {res_valid, res_taken, redir_valid, link_we, trap_req, annul}, 0);
        check("rst_buses", {cmp_op, cmp_a, redir_pc, link_addr}, 0);

        // directed cases
        do_op(4'd0,  1'b0, 32'd5, 32'd5, 16'h0004, 32'h100, 4'b0001, 0, 0, 0);        // BEQ taken
        do_op(4'd5,  1'b0, 32'hFFFFFFFF, 32'd0, 16'hFFFF, 32'h200, 4'b0001, 3, 0, 0); // BLTZAL stall
        do_op(4'd13, 1'b0, 32'd1, 32'h80000000, 16'h0000, 32'h300, 4'b1000, 0, 2, 0); // TLTU trap
        do_op(4'd10, 1'b0, 32'd1, 32'd2, 16'h0000, 32'h400, 4'b0000, 0, 0, 0);        // TGE not
        do_op(4'd0,  1'b0, 32'd7, 32'd7, 16'h0010, 32'h500, 4'b0001, 6, 0, 4);        // flush
        do_op(4'd1,  1'b1, 32'd3, 32'd3, 16'h0008, 32'h600, 4'b0000, 0, 0, 0);        // BNE likely
        do_op(4'd0,  1'b0, 32'd0, 32'd0, 16'h0004, 32'hFFFFFFF8, 4'b0001, 0, 0, 0);   // wrap
        do_op(4'd3,  1'b0, 32'h80000000, 32'd0, 16'h0002, 32'h700, 4'b0000, 0, 0, 0); // BGEZAL not
        do_op(4'd14, 1'b0, 32'd1, 32'd1, 16'h0001, 32'h800, 4'b1111, 0, 0, 0);        // illegal
        do_op(4'd11, 1'b1, 32'd9, 32'd4, 16'h0000, 32'h900, 4'b1000, 0, 0, 0);        // TGEU trap

        // random sweep
        for (int i = 0; i < 24; i++) begin
            do_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  16'($urandom), $urandom & 32'hFFFFFFFC, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        @(negedge clk);
        check("res_q_empty", res_q.size(), 0);
        check("redir_q_empty", redir_q.size(), 0);
        check("trap_q_empty", trap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
